// File: rtl/wb_stage.sv
// Write-back stage of the RV32I pipeline. It holds the MEM/WB register, waits on
// variable-latency load responses, aligns load data and drives the register-file write port.
module wb_stage #(
  parameter int unsigned MAX_WAIT     = 16,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  MemReadM,
  input  logic [4:0]  RdM,
  input  logic [31:0] AluResultM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ExtimmM,
  input  logic        FlushW,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ResultW,
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic        StallW,
  output logic [31:0] instret,
  output logic        load_err
);

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [1:0]  src;
    logic [2:0]  memread;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
  } wreg_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  wreg_t             w_q, w_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_load;
  logic              complete;
  logic              timeout;
  logic              stall;
  logic [31:0]       load_data;
  logic [31:0]       mux_out;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  // Next W-register contents; a flush kills the entry on its way in.
  always_comb begin
    w_d          = '0;
    w_d.valid    = ValidM & ~FlushW;
    w_d.regwrite = RegWriteM;
    w_d.src      = ResultSrcM;
    w_d.memread  = MemReadM;
    w_d.rd       = RdM;
    w_d.alu      = AluResultM;
    w_d.pc4      = PCPlus4M;
    w_d.imm      = ExtimmM;
  end

  assign is_load = (w_q.src == 2'b01) && (w_q.memread != 3'b000) && (w_q.memread <= 3'b101);

  // Load handshake: decide stall, completion and timeout for the current entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_q.valid && is_load && !dmem_rvalid) begin
          stall   = 1'b1;
          state_d = S_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (w_q.valid) begin
          complete = 1'b1;
        end
      end
      S_WAIT: begin
        if (FlushW) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (dmem_rvalid) begin
          complete = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
          complete = 1'b1;
          timeout  = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Byte/halfword selection from the word-aligned response.
  always_comb begin
    case (w_q.alu[1:0])
      2'b00:   sel_byte = dmem_rdata[7:0];
      2'b01:   sel_byte = dmem_rdata[15:8];
      2'b10:   sel_byte = dmem_rdata[23:16];
      default: sel_byte = dmem_rdata[31:24];
    endcase
    sel_half = w_q.alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (w_q.memread)
      3'b001:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b010:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    case (w_q.src)
      2'b00:   mux_out = w_q.alu;
      2'b01:   mux_out = load_data;
      2'b10:   mux_out = w_q.pc4;
      default: mux_out = w_q.imm;
    endcase
  end

  assign ResultW   = timeout ? TIMEOUT_DATA : mux_out;
  assign RegWriteW = complete & w_q.regwrite & (w_q.rd != 5'd0);
  assign RdW       = w_q.rd;
  assign StallW    = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q      <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      instret  <= '0;
      load_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!stall) w_q <= w_d;
      if (complete) instret <= instret + 32'd1;
      if (timeout) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a table of single-entry vectors plus hand-written
// sequences for late loads, timeout, flush and asynchronous reset.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, RegWriteM, FlushW, dmem_rvalid;
  logic [1:0]  ResultSrcM;
  logic [2:0]  MemReadM;
  logic [4:0]  RdM;
  logic [31:0] AluResultM, PCPlus4M, ExtimmM, dmem_rdata;
  logic [31:0] ResultW, instret;
  logic        RegWriteW, StallW, load_err;
  logic [4:0]  RdW;

  int tests = 0;
  int errors = 0;
  logic [31:0] exp_ir = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemReadM(MemReadM), .RdM(RdM), .AluResultM(AluResultM), .PCPlus4M(PCPlus4M),
    .ExtimmM(ExtimmM), .FlushW(FlushW), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .ResultW(ResultW), .RegWriteW(RegWriteW), .RdW(RdW), .StallW(StallW),
    .instret(instret), .load_err(load_err)
  );

  typedef struct {
    logic        valid, flush, rw;
    logic [1:0]  src;
    logic [2:0]  mr;
    logic [4:0]  rd;
    logic [31:0] alu, pc4, imm;
    logic        rvalid;
    logic [31:0] rdata, exp_res;
    logic        exp_rw, chk_res;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic valid, logic flush, logic rw, logic [1:0] src, logic [2:0] mr,
                              logic [4:0] rd, logic [31:0] alu, logic [31:0] pc4, logic [31:0] imm,
                              logic rvalid, logic [31:0] rdata, logic [31:0] exp_res,
                              logic exp_rw, logic chk_res);
    vec_t v;
    v.valid = valid; v.flush = flush; v.rw = rw; v.src = src; v.mr = mr; v.rd = rd;
    v.alu = alu; v.pc4 = pc4; v.imm = imm; v.rvalid = rvalid; v.rdata = rdata;
    v.exp_res = exp_res; v.exp_rw = exp_rw; v.chk_res = chk_res;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_m(input logic valid, input logic rw, input logic [1:0] src,
                         input logic [2:0] mr, input logic [4:0] rd, input logic [31:0] alu);
    ValidM = valid; RegWriteM = rw; ResultSrcM = src; MemReadM = mr; RdM = rd; AluResultM = alu;
  endtask

  initial begin
    int n;
    vecs[0]  = mk(1,0,1,2'b00,3'b000,5'd5, 32'h1234,0,0,0,0,32'h0000_1234,1,1);
    vecs[1]  = mk(1,0,1,2'b11,3'b000,5'd3, 0,0,32'hABCD_E000,0,0,32'hABCD_E000,1,1);
    vecs[2]  = mk(1,0,1,2'b10,3'b000,5'd1, 0,32'h104,0,0,0,32'h0000_0104,1,1);
    vecs[3]  = mk(1,0,1,2'b10,3'b000,5'd0, 0,32'h104,0,0,0,32'h0000_0104,0,1);
    vecs[4]  = mk(1,0,1,2'b01,3'b101,5'd9, 32'h1002,0,0,1,32'h9ABC_5678,32'h0000_9ABC,1,1);
    vecs[5]  = mk(1,0,1,2'b01,3'b010,5'd9, 32'h1002,0,0,1,32'h9ABC_5678,32'hFFFF_9ABC,1,1);
    vecs[6]  = mk(1,0,1,2'b01,3'b001,5'd7, 32'h1000,0,0,1,32'h80FF_1234,32'h0000_0034,1,1);
    vecs[7]  = mk(1,0,1,2'b01,3'b001,5'd7, 32'h1001,0,0,1,32'h80FF_1234,32'h0000_0012,1,1);
    vecs[8]  = mk(1,0,1,2'b01,3'b001,5'd7, 32'h1002,0,0,1,32'h80FF_1234,32'hFFFF_FFFF,1,1);
    vecs[9]  = mk(1,0,1,2'b01,3'b100,5'd7, 32'h1002,0,0,1,32'h80FF_1234,32'h0000_00FF,1,1);
    vecs[10] = mk(1,0,1,2'b01,3'b001,5'd7, 32'h1003,0,0,1,32'h80FF_1234,32'hFFFF_FF80,1,1);
    vecs[11] = mk(1,0,1,2'b01,3'b011,5'd10,32'h2000,0,0,1,32'hCAFE_F00D,32'hCAFE_F00D,1,1);
    vecs[12] = mk(1,0,1,2'b01,3'b101,5'd8, 32'h1003,0,0,1,32'h80FF_1234,32'h0000_80FF,1,1);
    vecs[13] = mk(1,0,1,2'b01,3'b010,5'd8, 32'h1001,0,0,1,32'h80FF_1234,32'h0000_1234,1,1);
    vecs[14] = mk(1,0,0,2'b00,3'b000,5'd6, 32'h55,0,0,0,0,32'h0000_0055,0,1);
    vecs[15] = mk(1,0,1,2'b01,3'b110,5'd4, 32'h10,0,0,0,32'h1111_2222,0,1,0);
    vecs[16] = mk(1,1,1,2'b00,3'b000,5'd5, 32'h77,0,0,0,0,32'h0000_0077,0,1);
    vecs[17] = mk(0,0,1,2'b00,3'b000,5'd5, 32'h88,0,0,1,32'h1234_5678,32'h0000_0088,0,1);

    rst = 1'b0; FlushW = 0; dmem_rvalid = 0; dmem_rdata = 0; PCPlus4M = 0; ExtimmM = 0;
    drive_m(0,0,2'b00,3'b000,5'd0,32'h0);
    #12;
    chk("rst_result", ResultW, 0);
    chk("rst_regwrite", 32'(RegWriteW), 0);
    chk("rst_rd", 32'(RdW), 0);
    chk("rst_stall", 32'(StallW), 0);
    chk("rst_instret", instret, 0);
    chk("rst_load_err", 32'(load_err), 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Table: capture one entry, answer any load in the following cycle.
    for (int i = 0; i < 18; i++) begin
      drive_m(vecs[i].valid, vecs[i].rw, vecs[i].src, vecs[i].mr, vecs[i].rd, vecs[i].alu);
      PCPlus4M = vecs[i].pc4; ExtimmM = vecs[i].imm; FlushW = vecs[i].flush;
      @(negedge clk);
      ValidM = 0; FlushW = 0; dmem_rvalid = vecs[i].rvalid; dmem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(StallW), 0);
      chk($sformatf("v%0d_regwrite", i), 32'(RegWriteW), 32'(vecs[i].exp_rw));
      chk($sformatf("v%0d_rd", i), 32'(RdW), 32'(vecs[i].rd));
      if (vecs[i].chk_res) chk($sformatf("v%0d_result", i), ResultW, vecs[i].exp_res);
      if (vecs[i].valid && !vecs[i].flush) exp_ir = exp_ir + 32'd1;
      @(negedge clk);
      dmem_rvalid = 0;
      chk($sformatf("v%0d_instret", i), instret, exp_ir);
    end

    // LB x7, offset 3, response three cycles late.
    drive_m(1,1,2'b01,3'b001,5'd7,32'h3003);
    @(negedge clk); ValidM = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lb_late_stall%0d", c), 32'(StallW), 1);
      chk($sformatf("lb_late_rw%0d", c), 32'(RegWriteW), 0);
      @(negedge clk);
    end
    dmem_rvalid = 1; dmem_rdata = 32'h80FF_1234; #1;
    chk("lb_late_stall_end", 32'(StallW), 0);
    chk("lb_late_rw", 32'(RegWriteW), 1);
    chk("lb_late_result", ResultW, 32'hFFFF_FF80);
    exp_ir = exp_ir + 32'd1;
    @(negedge clk); dmem_rvalid = 0; #1;
    chk("lb_late_rw_single", 32'(RegWriteW), 0);
    chk("lb_late_instret", instret, exp_ir);
    chk("lb_late_no_err", 32'(load_err), 0);

    // LW x11 never answered: 16 stall cycles, then timeout data.
    @(negedge clk);
    drive_m(1,1,2'b01,3'b011,5'd11,32'h4000);
    @(negedge clk); ValidM = 0; #1;
    n = 0;
    while (StallW && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    chk("to_stall_cycles", 32'(n), 16);
    chk("to_result", ResultW, 32'hDEAD_BEEF);
    chk("to_rw", 32'(RegWriteW), 1);
    chk("to_rd", 32'(RdW), 11);
    exp_ir = exp_ir + 32'd1;
    @(negedge clk);
    chk("to_load_err", 32'(load_err), 1);
    chk("to_instret", instret, exp_ir);
    drive_m(1,1,2'b00,3'b000,5'd2,32'h99);
    @(negedge clk); ValidM = 0; #1;
    chk("to_after_add_rw", 32'(RegWriteW), 1);
    exp_ir = exp_ir + 32'd1;
    @(negedge clk);
    chk("to_err_sticky", 32'(load_err), 1);

    // Flush while waiting, late response ignored.
    drive_m(1,1,2'b01,3'b011,5'd12,32'h5000);
    @(negedge clk); ValidM = 0; #1;
    chk("fl_stall_before", 32'(StallW), 1);
    @(negedge clk); #1;
    chk("fl_stall_wait", 32'(StallW), 1);
    FlushW = 1; #1;
    chk("fl_stall_drop", 32'(StallW), 0);
    chk("fl_rw", 32'(RegWriteW), 0);
    @(negedge clk); FlushW = 0;
    @(negedge clk);
    dmem_rvalid = 1; dmem_rdata = 32'h1234_5678; #1;
    chk("fl_stray_rw", 32'(RegWriteW), 0);
    chk("fl_stray_stall", 32'(StallW), 0);
    @(negedge clk); dmem_rvalid = 0;
    chk("fl_instret", instret, exp_ir);

    // Flush and response in the same waiting cycle: flush wins.
    drive_m(1,1,2'b01,3'b011,5'd13,32'h6000);
    @(negedge clk); ValidM = 0;
    @(negedge clk);
    FlushW = 1; dmem_rvalid = 1; dmem_rdata = 32'hAAAA_5555; #1;
    chk("flrv_rw", 32'(RegWriteW), 0);
    chk("flrv_stall", 32'(StallW), 0);
    @(negedge clk); FlushW = 0; dmem_rvalid = 0;
    chk("flrv_instret", instret, exp_ir);

    // Asynchronous reset in the middle of a wait.
    drive_m(1,1,2'b01,3'b011,5'd14,32'h7004);
    @(negedge clk); ValidM = 0;
    @(negedge clk); #1;
    chk("arst_pre_stall", 32'(StallW), 1);
    #2; rst = 1'b0; #1;
    chk("arst_stall", 32'(StallW), 0);
    chk("arst_rw", 32'(RegWriteW), 0);
    chk("arst_rd", 32'(RdW), 0);
    chk("arst_result", ResultW, 0);
    chk("arst_instret", instret, 0);
    chk("arst_load_err", 32'(load_err), 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("arst_idle_stall", 32'(StallW), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 5-stage RV32I pipeline. It holds the MEM/WB pipeline register and waits on variable-latency data-memory load responses. It aligns and sign- or zero-extends load data, selects the final result, and drives ResultW/RegWriteW/RdW back into the decode-stage register file. It stalls the upstream pipeline while a load response is outstanding, and keeps a retired-instruction counter and a sticky load-timeout error.

Parameters:
MAX_WAIT, 16, maximum cycles a load may wait for dmem_rvalid before timeout (1..255)
TIMEOUT_DATA, 32'hDEADBEEF, value written back on load timeout

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
ValidM  input  1  MEM-stage entry valid
RegWriteM  input  1  register write enable
ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4, 11 ExtImm
MemReadM  input  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as none
RdM  input  5  destination register
AluResultM  input  32  ALU result / load address
PCPlus4M  input  32  return address for JAL/JALR
ExtimmM  input  32  immediate for LUI
FlushW  input  1  kill the W entry (trap/redirect)
dmem_rvalid  input  1  load response valid, single-cycle pulse
dmem_rdata  input  32  raw word-aligned load data
ResultW  output  32  write-back data
RegWriteW  output  1  register write strobe, single cycle per instruction
RdW  output  5  write-back register address
StallW  output  1  hold IF..MEM; the W register does not advance
instret  output  32  committed-instruction count
load_err  output  1  sticky load-timeout flag

Behaviour:
- Reset (rst=0, asynchronous): W register valid=0, all captured fields 0, state IDLE, wait counter 0, instret=0, load_err=0. Outputs: ResultW=0, RegWriteW=0, RdW=0, StallW=0.
- Capture: on a clock edge with StallW=0, the W register loads all M inputs, with valid_q <= ValidM & ~FlushW. A load-type entry is one with MemRead in {001..101} and ResultSrc=01.
- FSM with states IDLE and WAIT:
  - IDLE: if valid_q, the entry is a load, and dmem_rvalid=0 -> go to WAIT, StallW=1 in this same cycle (combinational), wait counter=1.
  - IDLE: if the entry is a non-load, or a load with dmem_rvalid=1 this cycle -> the entry completes this cycle.
  - WAIT: StallW=1 and the counter increments each cycle.
  - WAIT, dmem_rvalid=1 -> the entry completes this cycle, StallW=0, go to IDLE.
  - WAIT, counter reaches MAX_WAIT with no rvalid -> the entry completes with ResultW=TIMEOUT_DATA, load_err<=1 (sticky until reset), go to IDLE.
- Completion cycle: RegWriteW = valid_q & RegWrite_q & (Rd_q!=0). It is never asserted for x0 and never asserted while StallW=1. instret increments by 1 for every completed valid entry, including x0, non-writing and timeout entries. instret wraps 0xFFFFFFFF->0.
- RdW = Rd_q at all times. ResultW is valid only when RegWriteW=1; at other times it holds the mux output.
- Load alignment uses offset AluResult_q[1:0]:
  - LB/LBU select byte [8*off+7:8*off].
  - LH/LHU select halfword off[1] (off[0] is ignored; misalignment is handled upstream).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes dmem_rdata unchanged.
- Result mux: 00 AluResult_q, 01 aligned load, 10 PCPlus4_q, 11 Extimm_q.
- dmem_rvalid arriving in IDLE with no pending load (stray response): ignored, no error.
- FlushW=1 while in WAIT: valid_q<=0, go to IDLE, StallW deasserts the same cycle. There is no write-back and no instret increment. A late rvalid for the flushed load is ignored as stray.
- FlushW and dmem_rvalid in the same WAIT cycle: flush wins; no write.
- Reset asserted mid-WAIT: immediate return to IDLE with all outputs at reset values.

Test Plan:
- ADD to x5, AluResultM=0x0000_1234, ResultSrc=00 -> next cycle RegWriteW=1, RdW=5, ResultW=0x1234, StallW=0, instret 0->1.
- LB to x7, addr low bits 2'b11, dmem_rdata=0x80FF_1234 arriving 3 cycles late -> StallW=1 for 3 cycles, then ResultW=0xFFFF_FF80, RegWriteW=1 for one cycle.
- LHU, addr bits 2'b10, rdata=0x9ABC_5678 with rvalid in the capture cycle -> no stall, ResultW=0x0000_9ABC.
- Load never answered -> StallW high for MAX_WAIT(16) cycles, then ResultW=0xDEADBEEF, load_err=1 and stays 1 across later instructions.
- Load in WAIT, FlushW pulsed, then rvalid 2 cycles later -> no RegWriteW, instret unchanged, StallW low from the flush cycle.
- JAL with Rd=x0, PCPlus4M=0x104 -> RegWriteW stays 0, instret increments; rst pulled low mid-WAIT -> all outputs return to 0 asynchronously.
